// File: rtl/bp_pkg.sv
// ============================================================================
// Module  : bp_pkg
// Brief   : Shared encodings, entry status type and helpers for the predictor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag and target widths follow the AWIDTH/ENTRIES parameters of the
  // top module, so they are kept in parallel arrays beside this record.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bp_entry_t;

  function automatic logic [1:0] bp_alloc_ctr(input logic taken);
    return taken ? WT : WNT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// Module  : bp_sat_counter
// Brief   : 2-bit saturating direction counter next-state with allocate input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_alloc,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_alloc) begin
      o_ctr = bp_alloc_ctr(i_taken);
    end else if (i_taken) begin
      if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module  : branch_target_predictor
// Brief   : Direct-mapped BTB with 2-bit direction counters, fetch lookup,
//           execute-stage training and branch/mispredict counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int ENTRIES = 16,
  parameter int CWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] i_pc_f,
  input  logic [AWIDTH-1:0] i_pc_x,
  input  logic [AWIDTH-1:0] i_target_x,
  input  logic              i_Br_x,
  input  logic              i_BrTrue,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_BrPred,
  output logic              o_Target_valid,
  output logic [AWIDTH-1:0] o_target_f,
  output logic              o_BrPred_x,
  output logic [CWIDTH-1:0] o_br_count,
  output logic [CWIDTH-1:0] o_mispred_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = AWIDTH - IDX - 2;

  bp_entry_t         r_meta   [ENTRIES];
  logic [TW-1:0]     r_tag    [ENTRIES];
  logic [AWIDTH-1:0] r_target [ENTRIES];

  logic              r_BrPred_x;
  logic [CWIDTH-1:0] r_br_count;
  logic [CWIDTH-1:0] r_mispred_count;

  logic [IDX-1:0] w_idx_f;
  logic [IDX-1:0] w_idx_x;
  logic [TW-1:0]  w_tag_f;
  logic [TW-1:0]  w_tag_x;
  logic           w_hit_f;
  logic           w_hit_x;
  logic           w_upd;
  logic [1:0]     w_ctr_next;
  logic           w_unused_pc_lsb;

  assign w_idx_f = i_pc_f[IDX+1:2];
  assign w_idx_x = i_pc_x[IDX+1:2];
  assign w_tag_f = i_pc_f[AWIDTH-1:IDX+2];
  assign w_tag_x = i_pc_x[AWIDTH-1:IDX+2];
  assign w_unused_pc_lsb = ^{i_pc_f[1:0], i_pc_x[1:0]};

  assign w_hit_f = r_meta[w_idx_f].valid && (r_tag[w_idx_f] == w_tag_f);
  assign w_hit_x = r_meta[w_idx_x].valid && (r_tag[w_idx_x] == w_tag_x);
  assign w_upd   = i_Br_x && !i_stall;

  // Lookup reads the flop array directly, so a same-cycle update is unseen.
  assign o_Target_valid = w_hit_f;
  assign o_BrPred       = w_hit_f && r_meta[w_idx_f].ctr[1];
  assign o_target_f     = w_hit_f ? r_target[w_idx_f] : '0;

  bp_sat_counter u_sat_counter (
    .i_ctr   (r_meta[w_idx_x].ctr),
    .i_taken (i_BrTrue),
    .i_alloc (!w_hit_x),
    .o_ctr   (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_meta[i].valid <= 1'b0;
        r_meta[i].ctr   <= WNT;
        r_tag[i]        <= '0;
        r_target[i]     <= '0;
      end
    end else if (w_upd) begin
      // A tag mismatch at the index simply overwrites the resident entry.
      r_meta[w_idx_x].valid <= 1'b1;
      r_meta[w_idx_x].ctr   <= w_ctr_next;
      r_tag[w_idx_x]        <= w_tag_x;
      if (!w_hit_x || i_BrTrue) r_target[w_idx_x] <= i_target_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_BrPred_x      <= 1'b0;
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (i_flush)       r_BrPred_x <= 1'b0;
      else if (!i_stall) r_BrPred_x <= o_BrPred;

      if (w_upd) begin
        r_br_count <= r_br_count + CWIDTH'(1);
        if (i_BrTrue != r_BrPred_x) r_mispred_count <= r_mispred_count + CWIDTH'(1);
      end
    end
  end

  assign o_BrPred_x      = r_BrPred_x;
  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// Module  : tb_branch_target_predictor
// Brief   : Directed vector table plus hand sequences for the BTB predictor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f, pc_x, target_x;
  logic        br_x, br_true, stall, flush;
  logic        br_pred, target_valid, br_pred_x;
  logic [31:0] target_f, br_count, mispred_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc_f;
    logic        br;
    logic        tk;
    logic [31:0] pc_x;
    logic [31:0] tgt;
    logic        st;
    logic        fl;
    logic        exp_pred;
    logic        exp_tv;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  branch_target_predictor #(.AWIDTH(32), .ENTRIES(16), .CWIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_pc_f          (pc_f),
    .i_pc_x          (pc_x),
    .i_target_x      (target_x),
    .i_Br_x          (br_x),
    .i_BrTrue        (br_true),
    .i_stall         (stall),
    .i_flush         (flush),
    .o_BrPred        (br_pred),
    .o_Target_valid  (target_valid),
    .o_target_f      (target_f),
    .o_BrPred_x      (br_pred_x),
    .o_br_count      (br_count),
    .o_mispred_count (mispred_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lookup results are checked before the edge, i.e. against the pre-update table.
  task automatic add(input logic [31:0] f, input logic b, input logic t, input logic [31:0] x,
                     input logic [31:0] g, input logic s, input logic l,
                     input logic ep, input logic ev, input logic [31:0] et);
    vec_t v;
    v.pc_f = f; v.br = b; v.tk = t; v.pc_x = x; v.tgt = g; v.st = s; v.fl = l;
    v.exp_pred = ep; v.exp_tv = ev; v.exp_tgt = et;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] f, input logic b, input logic t, input logic [31:0] x,
                       input logic [31:0] g, input logic s, input logic l);
    pc_f = f; br_x = b; br_true = t; pc_x = x; target_x = g; stall = s; flush = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h40, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset pred", {31'd0, br_pred}, 0);
    check("reset tv", {31'd0, target_valid}, 0);
    check("reset tgt", target_f, 0);
    check("reset predx", {31'd0, br_pred_x}, 0);
    check("reset brcnt", br_count, 0);
    check("reset miscnt", mispred_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    //   pc_f            br tk pc_x            tgt          st fl  pred tv  tgt
    add(32'h40,          1, 1, 32'h40,         32'h80,      0, 0,  0, 0, 32'h0);
    add(32'h40,          1, 1, 32'h40,         32'h80,      0, 0,  1, 1, 32'h80);
    add(32'h40,          1, 1, 32'h40,         32'h80,      0, 0,  1, 1, 32'h80);
    add(32'h40,          1, 1, 32'h40,         32'h80,      0, 0,  1, 1, 32'h80);
    add(32'h40,          1, 1, 32'h40,         32'h80,      0, 0,  1, 1, 32'h80);
    add(32'h40,          1, 0, 32'h40,         32'h99C,     0, 0,  1, 1, 32'h80);
    add(32'h40,          1, 0, 32'h40,         32'h99C,     0, 0,  1, 1, 32'h80);
    add(32'h40,          0, 0, 32'h0,          32'h0,       0, 0,  0, 1, 32'h80);
    add(32'h40,          1, 0, 32'h40,         32'h99C,     0, 0,  0, 1, 32'h80);
    add(32'h40,          1, 0, 32'h40,         32'h99C,     0, 0,  0, 1, 32'h80);
    add(32'h40,          1, 1, 32'h40,         32'h100,     0, 0,  0, 1, 32'h80);
    add(32'h40,          0, 0, 32'h0,          32'h0,       0, 0,  0, 1, 32'h100);
    add(32'h40,          1, 1, 32'h40,         32'h100,     0, 0,  0, 1, 32'h100);
    add(32'h40,          0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h100);
    add(32'h43,          0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h100);
    add(32'h40,          1, 0, 32'h40,         32'h0,       1, 0,  1, 1, 32'h100);
    add(32'h40,          1, 0, 32'h40,         32'h0,       1, 0,  1, 1, 32'h100);
    add(32'h40,          1, 0, 32'h40,         32'h0,       1, 0,  1, 1, 32'h100);
    add(32'h80,          1, 1, 32'h80,         32'h200,     0, 0,  0, 0, 32'h0);
    add(32'h40,          0, 0, 32'h0,          32'h0,       0, 0,  0, 0, 32'h0);
    add(32'h80,          0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h200);
    add(32'h44,          1, 0, 32'h44,         32'h300,     0, 0,  0, 0, 32'h0);
    add(32'h44,          0, 0, 32'h0,          32'h0,       0, 0,  0, 1, 32'h300);
    add(32'h44,          1, 1, 32'h44,         32'h304,     0, 1,  0, 1, 32'h300);
    add(32'h44,          0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h304);
    add(32'h80,          1, 1, 32'h80,         32'h500,     1, 1,  1, 1, 32'h200);
    add(32'h80,          0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h200);
    add(32'h80,          1, 1, 32'hFFFF_FFC0,  32'h1234,    0, 0,  1, 1, 32'h200);
    add(32'hFFFF_FFC0,   0, 0, 32'h0,          32'h0,       0, 0,  1, 1, 32'h1234);
    add(32'h80,          0, 0, 32'h0,          32'h0,       0, 0,  0, 0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].pc_f, vecs[i].br, vecs[i].tk, vecs[i].pc_x, vecs[i].tgt, vecs[i].st, vecs[i].fl);
      #1;
      check($sformatf("v%0d pred", i), {31'd0, br_pred}, {31'd0, vecs[i].exp_pred});
      check($sformatf("v%0d tv", i), {31'd0, target_valid}, {31'd0, vecs[i].exp_tv});
      check($sformatf("v%0d tgt", i), target_f, vecs[i].exp_tgt);
      tick();
    end

    // Asynchronous reset asserted away from any clock edge.
    drive(32'hFFFF_FFC0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst tv", {31'd0, target_valid}, 0);
    check("midrst pred", {31'd0, br_pred}, 0);
    check("midrst tgt", target_f, 0);
    check("midrst brcnt", br_count, 0);
    check("midrst miscnt", mispred_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Counter / BrPred_x sequence from a cold table.
    drive(32'h0, 1, 1, 32'h40, 32'h80, 0, 0);
    tick();
    check("s1 brcnt", br_count, 1);
    check("s1 miscnt", mispred_count, 1);
    check("s1 predx", {31'd0, br_pred_x}, 0);

    drive(32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    tick();
    check("s2 predx", {31'd0, br_pred_x}, 1);

    for (int k = 0; k < 3; k++) begin
      drive(32'h0, 1, 0, 32'h40, 32'h0, 1, 0);
      tick();
      check($sformatf("stall%0d brcnt", k), br_count, 1);
      check($sformatf("stall%0d predx", k), {31'd0, br_pred_x}, 1);
    end
    drive(32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    check("stall ctr kept", {31'd0, br_pred}, 1);
    tick();

    drive(32'h40, 1, 0, 32'h40, 32'h0, 0, 0);
    #1;
    check("rbw old pred", {31'd0, br_pred}, 1);
    tick();
    check("rbw new pred", {31'd0, br_pred}, 0);
    check("s5 brcnt", br_count, 2);
    check("s5 miscnt", mispred_count, 2);
    check("s5 predx", {31'd0, br_pred_x}, 1);

    drive(32'h40, 1, 0, 32'h40, 32'h0, 0, 1);
    tick();
    check("flush predx", {31'd0, br_pred_x}, 0);
    check("flush brcnt", br_count, 3);
    check("flush miscnt", mispred_count, 3);

    drive(32'h0, 1, 1, 32'h40, 32'h0, 1, 1);
    tick();
    check("stfl brcnt", br_count, 3);
    check("stfl miscnt", mispred_count, 3);
    check("stfl predx", {31'd0, br_pred_x}, 0);

    drive(32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
